// File: rtl/load_unit_if.sv
// Execute-stage load request, data-memory read port and load result, bundled
// so the load unit and its environment share one set of signal names.
interface load_unit_if;
    logic        ld_req_in;
    logic [2:0]  fun_3_in;
    logic [31:0] iadder_in;
    logic        dm_rd_req_o;
    logic [31:0] dm_addr_o;
    logic        dm_rd_ack_in;
    logic [31:0] dm_data_in;
    logic [31:0] lu_data_o;
    logic        lu_valid_o;
    logic        lu_busy_o;
    logic        lu_fault_o;

    // slave: the load unit itself
    modport slave (
        input  ld_req_in, fun_3_in, iadder_in, dm_rd_ack_in, dm_data_in,
        output dm_rd_req_o, dm_addr_o, lu_data_o, lu_valid_o, lu_busy_o, lu_fault_o
    );

    // master: pipeline and data memory driving the load unit
    modport master (
        output ld_req_in, fun_3_in, iadder_in, dm_rd_ack_in, dm_data_in,
        input  dm_rd_req_o, dm_addr_o, lu_data_o, lu_valid_o, lu_busy_o, lu_fault_o
    );
endinterface

// File: rtl/load_unit.sv
// RV32I load unit: checks and issues a word-aligned memory read, waits for the
// acknowledge (with timeout), then extracts and extends the addressed byte/half.
//
// state  | meaning
// S_IDLE | no access outstanding; ld_req_in is checked and accepted here
// S_WAIT | read request held on the memory port until ack or timeout
module load_unit #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    load_unit_if.slave  bus
);
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       fun3_q, fun3_nxt;
    logic [1:0]       off_q, off_nxt;
    logic [31:0]      addr_q, addr_nxt;
    logic [31:0]      data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             fault_q, fault_nxt;

    logic             req_bad;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ext_data;

    always_comb begin
        req_bad = 1'b0;
        case (bus.fun_3_in)
            F3_LB, F3_LBU: req_bad = 1'b0;
            F3_LH, F3_LHU: req_bad = bus.iadder_in[0];
            F3_LW:         req_bad = (bus.iadder_in[1:0] != 2'b00);
            default:       req_bad = 1'b1;
        endcase
    end

    // Lane selection uses the offset captured at issue, not the live address.
    always_comb begin
        byte_sel = 8'h00;
        case (off_q)
            2'd0: byte_sel = bus.dm_data_in[7:0];
            2'd1: byte_sel = bus.dm_data_in[15:8];
            2'd2: byte_sel = bus.dm_data_in[23:16];
            2'd3: byte_sel = bus.dm_data_in[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = off_q[1] ? bus.dm_data_in[31:16] : bus.dm_data_in[15:0];

        ext_data = bus.dm_data_in;
        case (fun3_q)
            F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ext_data = {24'h000000, byte_sel};
            F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ext_data = {16'h0000, half_sel};
            default: ext_data = bus.dm_data_in;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fun3_nxt  = fun3_q;
        off_nxt   = off_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        fault_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.ld_req_in) begin
                    if (req_bad) begin
                        fault_nxt = 1'b1;
                    end else begin
                        fun3_nxt  = bus.fun_3_in;
                        off_nxt   = bus.iadder_in[1:0];
                        addr_nxt  = {bus.iadder_in[31:2], 2'b00};
                        cnt_nxt   = '0;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // An ack in the last allowed cycle still completes the load.
                if (bus.dm_rd_ack_in) begin
                    data_nxt  = ext_data;
                    valid_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    fault_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fun3_q  <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fun3_q  <= fun3_nxt;
            off_q   <= off_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            fault_q <= fault_nxt;
        end
    end

    // Request and stall decode straight from the state flop so reset drops them at once.
    assign bus.dm_rd_req_o = (state == S_WAIT);
    assign bus.lu_busy_o   = (state == S_WAIT);
    assign bus.dm_addr_o   = addr_q;
    assign bus.lu_data_o   = data_q;
    assign bus.lu_valid_o  = valid_q;
    assign bus.lu_fault_o  = fault_q;
endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed cases from the load rules plus
// randomized loads checked against a transaction-level reference model.
module tb_load_unit;
    localparam int TO = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_data;

    load_unit_if bus();

    load_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (addr % 2) == 0;
            3'b010:         return (addr % 4) == 0;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_extract(input logic [2:0] f3, input logic [31:0] addr,
                                                  input logic [31:0] word);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = addr % 4;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    // One load: idle cycle (random ack ignored), issue, then up to TO wait cycles.
    // ack_at is the wait-cycle index carrying the ack; ack_at >= TO means no ack.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input int ack_at);
        bit legal;
        legal = model_legal(f3, addr);
        @(posedge clk); #1;
        bus.dm_rd_ack_in = 1'($urandom_range(0, 1));
        bus.dm_data_in   = $urandom;
        bus.ld_req_in    = 1'b1;
        bus.fun_3_in     = f3;
        bus.iadder_in    = addr;
        @(negedge clk);
        check_val("idle_valid", 32'(bus.lu_valid_o), 32'd0);
        check_val("idle_fault", 32'(bus.lu_fault_o), 32'd0);
        check_val("idle_req",   32'(bus.dm_rd_req_o), 32'd0);
        check_val("idle_data",  bus.lu_data_o, exp_data);
        @(posedge clk); #1;
        bus.ld_req_in    = 1'b0;
        bus.dm_rd_ack_in = 1'b0;
        if (!legal) begin
            @(negedge clk);
            check_val("bad_fault", 32'(bus.lu_fault_o), 32'd1);
            check_val("bad_req",   32'(bus.dm_rd_req_o), 32'd0);
            check_val("bad_valid", 32'(bus.lu_valid_o), 32'd0);
            check_val("bad_data",  bus.lu_data_o, exp_data);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check_val("wait_req",   32'(bus.dm_rd_req_o), 32'd1);
            check_val("wait_busy",  32'(bus.lu_busy_o), 32'd1);
            check_val("wait_addr",  bus.dm_addr_o, addr & 32'hFFFF_FFFC);
            check_val("wait_valid", 32'(bus.lu_valid_o), 32'd0);
            check_val("wait_fault", 32'(bus.lu_fault_o), 32'd0);
            if (k == ack_at) begin
                bus.dm_rd_ack_in = 1'b1;
                bus.dm_data_in   = word;
            end
            @(posedge clk); #1;
            bus.dm_rd_ack_in = 1'b0;
            bus.dm_data_in   = $urandom;
            if (k == ack_at) begin
                exp_data = model_extract(f3, addr, word);
                @(negedge clk);
                check_val("done_valid", 32'(bus.lu_valid_o), 32'd1);
                check_val("done_data",  bus.lu_data_o, exp_data);
                check_val("done_req",   32'(bus.dm_rd_req_o), 32'd0);
                check_val("done_busy",  32'(bus.lu_busy_o), 32'd0);
                check_val("done_fault", 32'(bus.lu_fault_o), 32'd0);
                return;
            end
        end
        @(negedge clk);
        check_val("to_fault", 32'(bus.lu_fault_o), 32'd1);
        check_val("to_valid", 32'(bus.lu_valid_o), 32'd0);
        check_val("to_req",   32'(bus.dm_rd_req_o), 32'd0);
        check_val("to_data",  bus.lu_data_o, exp_data);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   32'(bus.dm_rd_req_o), 32'd0);
        check_val({tag, "_busy"},  32'(bus.lu_busy_o), 32'd0);
        check_val({tag, "_addr"},  bus.dm_addr_o, 32'd0);
        check_val({tag, "_data"},  bus.lu_data_o, 32'd0);
        check_val({tag, "_valid"}, 32'(bus.lu_valid_o), 32'd0);
        check_val({tag, "_fault"}, 32'(bus.lu_fault_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        n_tests  = 0;
        n_fail   = 0;
        exp_data = 32'h0;
        rst = 1'b1;
        bus.ld_req_in    = 1'b0;
        bus.fun_3_in     = 3'b000;
        bus.iadder_in    = 32'h0;
        bus.dm_rd_ack_in = 1'b0;
        bus.dm_data_in   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst0");
        #1 rst = 1'b0;

        // Directed extraction cases
        run_load(3'b000, 32'h0000_1003, 32'h80AB_CDEF, 0);
        check_val("lb_value", exp_data, 32'hFFFF_FF80);
        run_load(3'b101, 32'h0000_2002, 32'h9234_5678, 0);
        run_load(3'b001, 32'h0000_2002, 32'h9234_5678, 1);
        run_load(3'b001, 32'h0000_2000, 32'h9234_5678, 0);
        run_load(3'b100, 32'h0000_2001, 32'h9234_F678, 2);
        run_load(3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 0);

        // Faults leave lu_data_o alone
        run_load(3'b010, 32'h0000_3001, 32'h1111_1111, 0);
        run_load(3'b110, 32'h0000_3000, 32'h1111_1111, 0);
        run_load(3'b011, 32'h0000_3000, 32'h1111_1111, 0);
        run_load(3'b101, 32'h0000_3003, 32'h1111_1111, 0);

        // Timeout, and ack on the final allowed cycle
        run_load(3'b010, 32'h0000_4000, 32'h2222_2222, TO + 3);
        run_load(3'b010, 32'h0000_4000, 32'hCAFE_F00D, TO - 1);

        // Back-to-back loads with ld_req_in held high
        @(posedge clk); #1;
        bus.ld_req_in = 1'b1; bus.fun_3_in = 3'b010; bus.iadder_in = 32'h10;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("b2b_addr0", bus.dm_addr_o, 32'h10);
        bus.dm_rd_ack_in = 1'b1; bus.dm_data_in = 32'hA5A5_0001; bus.iadder_in = 32'h14;
        @(posedge clk); #1;
        bus.dm_rd_ack_in = 1'b0;
        @(negedge clk);
        check_val("b2b_valid0", 32'(bus.lu_valid_o), 32'd1);
        check_val("b2b_data0",  bus.lu_data_o, 32'hA5A5_0001);
        @(posedge clk); #1;
        bus.ld_req_in = 1'b0;
        @(negedge clk);
        check_val("b2b_gap",   32'(bus.lu_valid_o), 32'd0);
        check_val("b2b_addr1", bus.dm_addr_o, 32'h14);
        check_val("b2b_req1",  32'(bus.dm_rd_req_o), 32'd1);
        bus.dm_rd_ack_in = 1'b1; bus.dm_data_in = 32'h5A5A_0002;
        @(posedge clk); #1;
        bus.dm_rd_ack_in = 1'b0;
        @(negedge clk);
        check_val("b2b_valid1", 32'(bus.lu_valid_o), 32'd1);
        check_val("b2b_data1",  bus.lu_data_o, 32'h5A5A_0002);
        exp_data = 32'h5A5A_0002;

        // Randomized loads against the reference model
        for (int i = 0; i < 300; i++) begin
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) f3 = 3'b000;
                if (f3 == 3'b010) addr[1:0] = 2'b00;
                if (f3 == 3'b001 || f3 == 3'b101) addr[0] = 1'b0;
            end
            run_load(f3, addr, $urandom, int'($urandom_range(0, TO + 1)));
        end

        // Reset mid-wait abandons the access
        @(posedge clk); #1;
        bus.ld_req_in = 1'b1; bus.fun_3_in = 3'b010; bus.iadder_in = 32'h40;
        @(posedge clk); #1;
        bus.ld_req_in = 1'b0;
        #2;
        check_val("abort_req_pre", 32'(bus.dm_rd_req_o), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_data = 32'h0;
        for (int i = 0; i < 6; i++) begin
            bus.dm_rd_ack_in = 1'b1;
            bus.dm_data_in   = $urandom;
            @(negedge clk);
            check_val("post_valid", 32'(bus.lu_valid_o), 32'd0);
            check_val("post_fault", 32'(bus.lu_fault_o), 32'd0);
            check_val("post_data",  bus.lu_data_o, 32'd0);
            @(posedge clk); #1;
        end
        bus.dm_rd_ack_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Read-side companion to the datapath store path. Accepts an RV32I load (LB/LH/LW/LBU/LHU) from the execute stage and issues a word-aligned read request to data memory. It holds the request until memory acknowledges, then extracts the addressed byte or halfword and sign- or zero-extends it. Returns the result with a one-cycle valid pulse and stalls the pipeline through busy while the access is outstanding.

Parameters:
TIMEOUT_CYCLES, 15, number of WAIT cycles without an acknowledge before the access is abandoned; legal range 1..255
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk_in  input  1  single clock; all state changes on the rising edge
rst_in  input  1  asynchronous, active-high reset
ld_req_in  input  1  load issue strobe; sampled only in IDLE
fun_3_in  input  3  load funct3 encoding
iadder_in  input  32  effective byte address
dm_rd_req_o  output  1  memory read request; held high for the whole WAIT state
dm_addr_o  output  32  registered word address, {addr[31:2],2'b00}
dm_rd_ack_in  input  1  memory acknowledge; dm_data_in is valid in the same cycle
dm_data_in  input  32  memory read word
lu_data_o  output  32  extended load result; holds its value until the next successful load
lu_valid_o  output  1  one-cycle pulse: lu_data_o is new
lu_busy_o  output  1  high in WAIT; pipeline stall
lu_fault_o  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (asynchronous, any state): state=IDLE; dm_rd_req_o=0; dm_addr_o=0; lu_data_o=0; lu_valid_o=0; lu_busy_o=0; lu_fault_o=0; counter=0; captured fun_3 and offset = 0.
- Reset asserted mid-WAIT abandons the access: request drops immediately, no valid and no fault.
- States: IDLE, WAIT. lu_valid_o and lu_fault_o are registered pulses, not states.
- IDLE, ld_req_in=1, request checks:
  - illegal funct3 (011, 110, 111) -> fault;
  - LH/LHU with addr[0]=1 -> fault;
  - LW with addr[1:0]!=0 -> fault;
  - on fault: lu_fault_o=1 for exactly the next cycle, no memory request, stay IDLE.
- IDLE, ld_req_in=1, request legal: capture fun_3 and addr[1:0], load dm_addr_o, clear the counter, go to WAIT. dm_rd_req_o and lu_busy_o are high from the next cycle.
- WAIT, dm_rd_ack_in=1:
  - compute the result from dm_data_in and the captured fields, register it into lu_data_o;
  - lu_valid_o=1 for exactly the next cycle; return to IDLE;
  - dm_rd_req_o and lu_busy_o drop in that same next cycle.
- WAIT, no ack:
  - counter increments each cycle;
  - when the counter reaches TIMEOUT_CYCLES-1 with no ack -> lu_fault_o pulse, return to IDLE, lu_data_o unchanged;
  - an ack in the final cycle wins over the timeout.
- Extraction uses the captured offset:
  - byte lane = offset*8;
  - halfword = upper half if offset[1]=1, else lower half;
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Latency: request accepted at edge N; ack sampled at edge M>=N+1; lu_valid_o high in cycle M+1. Minimum 2 cycles.
- ld_req_in in WAIT is ignored; the upstream stage must hold the request while lu_busy_o=1.
- ld_req_in in the lu_valid_o cycle is accepted (state is IDLE), so back-to-back loads are possible.
- dm_rd_ack_in in IDLE is ignored: no output change.
- dm_addr_o holds its last value in IDLE.

Test Plan:
- Reset: assert rst_in asynchronously mid-cycle -> all outputs 0 before the next edge; state IDLE.
- LB sign extension: iadder_in=0x1003, fun_3=000, dm_data_in=0x80AB_CDEF, ack one cycle after the request -> dm_addr_o=0x1000, lu_data_o=0xFFFF_FF80, lu_valid_o high exactly 1 cycle, total latency 2.
- LHU/LH: iadder_in=0x2002, dm_data_in=0x9234_5678 -> LHU gives 0x0000_9234, LH gives 0xFFFF_9234; at offset 0 LH gives 0x0000_5678.
- Fault cases:
  - LW at 0x3001 -> lu_fault_o 1-cycle pulse, dm_rd_req_o stays 0;
  - funct3=110 at an aligned address -> same response;
  - lu_data_o retains the previous value in both cases.
- Timeout: TIMEOUT_CYCLES=4, no ack -> dm_rd_req_o high 4 cycles, then lu_fault_o pulse, IDLE. Repeat with ack on the 4th cycle -> lu_valid_o and no fault.
- Back-to-back and reset-abort:
  - ld_req_in held high through two LW loads (0x10, 0x14) with ack on the first WAIT cycle -> valid pulses 2 cycles apart, correct words;
  - rst_in asserted during WAIT -> dm_rd_req_o drops immediately and no valid or fault is ever produced.
